// File: rtl/udma_pkg.sv
// Shared uDMA types: L2 data width, datasize encoding, write beat record
// and the lane-alignment helpers used on the L2 write path.
package udma_pkg;

  localparam int L2_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } udma_datasize_e;

  typedef struct packed {
    logic [31:0]              addr;
    logic [L2_DATA_WIDTH-1:0] data;
    logic [1:0]               datasize;
  } udma_wr_beat_t;

  // Encoding 3 is reserved and behaves like a full word.
  function automatic logic [3:0] l2_byte_enable(input logic [1:0] offset,
                                                input logic [1:0] datasize);
    case (datasize)
      BYTE:    return 4'b0001 << offset;
      HALF:    return offset[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [L2_DATA_WIDTH-1:0] l2_lane_data(input logic [L2_DATA_WIDTH-1:0] data,
                                                           input logic [1:0] datasize);
    case (datasize)
      BYTE:    return {4{data[7:0]}};
      HALF:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/udma_rr_picker.sv
// Combinational round-robin select: first set bit of the valid vector at or
// after the pointer, wrapping from N_CH-1 to 0.
module udma_rr_picker #(
  parameter int N_CH     = 4,
  parameter int ID_WIDTH = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]     valid,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [N_CH-1:0]     grant,
  output logic [ID_WIDTH-1:0] index,
  output logic                found
);

  localparam logic [ID_WIDTH:0] NUM_CH = (ID_WIDTH + 1)'(N_CH);

  logic [ID_WIDTH:0] slot;

  // One extra bit on the slot sum lets the wrap be a single conditional subtract.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    slot  = '0;
    for (int i = 0; i < N_CH; i++) begin
      slot = {1'b0, ptr} + (ID_WIDTH + 1)'(i);
      if (slot >= NUM_CH) slot = slot - NUM_CH;
      if (!found && valid[slot[ID_WIDTH-1:0]]) begin
        found = 1'b1;
        grant[slot[ID_WIDTH-1:0]] = 1'b1;
        index = slot[ID_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/udma_l2_wr_arbiter.sv
// Round-robin arbiter sharing the uDMA write-only L2 port between RX channels,
// with byte-lane alignment and a single-entry output register driving req/gnt.
module udma_l2_wr_arbiter
  import udma_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int ID_WIDTH = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                                sys_clk_i,
  input  logic                                sys_resetn_i,
  input  logic [N_CH-1:0]                     ch_valid_i,
  output logic [N_CH-1:0]                     ch_ready_o,
  input  logic [N_CH-1:0][31:0]               ch_addr_i,
  input  logic [N_CH-1:0][L2_DATA_WIDTH-1:0]  ch_data_i,
  input  logic [N_CH-1:0][1:0]                ch_datasize_i,
  output logic                                l2_req_o,
  input  logic                                l2_gnt_i,
  output logic [31:0]                         l2_addr_o,
  output logic [3:0]                          l2_be_o,
  output logic [L2_DATA_WIDTH-1:0]            l2_wdata_o,
  output logic [ID_WIDTH-1:0]                 l2_owner_o,
  output logic                                busy_o
);

  logic                full;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [N_CH-1:0]     win_grant;
  logic [ID_WIDTH-1:0] win_idx;
  logic                win_found;
  logic                accept;
  logic                load;
  udma_wr_beat_t       beats [N_CH];
  udma_wr_beat_t       win_beat;

  udma_rr_picker #(
    .N_CH     (N_CH),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .valid (ch_valid_i),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .index (win_idx),
    .found (win_found)
  );

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      beats[i] = '{addr: ch_addr_i[i], data: ch_data_i[i], datasize: ch_datasize_i[i]};
    end
  end

  assign win_beat = beats[win_idx];

  // A granted beat frees the register in the same cycle, so a new one may replace it.
  assign accept = ~full | l2_gnt_i;
  assign load   = accept & win_found;

  // Ready is masked during reset so no handshake completes while the register is cleared.
  assign ch_ready_o = (load && sys_resetn_i) ? win_grant : '0;

  always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
    if (!sys_resetn_i) begin
      full       <= 1'b0;
      rr_ptr     <= '0;
      l2_addr_o  <= '0;
      l2_be_o    <= '0;
      l2_wdata_o <= '0;
      l2_owner_o <= '0;
    end else if (load) begin
      full       <= 1'b1;
      l2_addr_o  <= {win_beat.addr[31:2], 2'b00};
      l2_be_o    <= l2_byte_enable(win_beat.addr[1:0], win_beat.datasize);
      l2_wdata_o <= l2_lane_data(win_beat.data, win_beat.datasize);
      l2_owner_o <= win_idx;
      rr_ptr     <= (win_idx == ID_WIDTH'(N_CH - 1)) ? '0 : win_idx + 1'b1;
    end else if (l2_gnt_i) begin
      full       <= 1'b0;
    end
  end

  assign l2_req_o = full;
  assign busy_o   = full;

endmodule

// File: tb/tb_udma_l2_wr_arbiter.sv
// Self-checking bench for udma_l2_wr_arbiter (N_CH=4) against a cycle-level
// reference model derived from the round-robin and lane-alignment rules.
module tb_udma_l2_wr_arbiter;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     valid;
  logic [N-1:0]     ready;
  logic [N-1:0][31:0] addr;
  logic [N-1:0][31:0] data;
  logic [N-1:0][1:0]  size;
  logic             gnt;
  logic             l2_req;
  logic [31:0]      l2_addr;
  logic [3:0]       l2_be;
  logic [31:0]      l2_wdata;
  logic [1:0]       l2_owner;
  logic             busy;

  int passed = 0;
  int total  = 0;

  bit          m_full;
  int          m_ptr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [1:0]  m_owner;

  always #5 clk = ~clk;

  udma_l2_wr_arbiter #(
    .N_CH     (N),
    .ID_WIDTH (2)
  ) dut (
    .sys_clk_i     (clk),
    .sys_resetn_i  (rst_n),
    .ch_valid_i    (valid),
    .ch_ready_o    (ready),
    .ch_addr_i     (addr),
    .ch_data_i     (data),
    .ch_datasize_i (size),
    .l2_req_o      (l2_req),
    .l2_gnt_i      (gnt),
    .l2_addr_o     (l2_addr),
    .l2_be_o       (l2_be),
    .l2_wdata_o    (l2_wdata),
    .l2_owner_o    (l2_owner),
    .busy_o        (busy)
  );

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int c = (m_ptr + k) % N;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int w = pick();
    if (w >= 0 && (!m_full || gnt)) return 4'(1 << w);
    return 4'b0000;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] s);
    int off = int'(a % 4);
    if (s == 2'd0) return 4'(1 << off);
    if (s == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] s);
    if (s == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (s == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  task automatic model_reset();
    m_full = 0; m_ptr = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_owner = '0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    int w = pick();
    bit acc = !m_full || gnt;
    @(posedge clk);
    if (acc && w >= 0) begin
      m_full  = 1;
      m_addr  = addr[w] & ~32'h3;
      m_be    = ref_be(addr[w], size[w]);
      m_wdata = ref_wdata(data[w], size[w]);
      m_owner = 2'(w);
      m_ptr   = (w + 1) % N;
    end else if (gnt) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = '0; gnt = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain();
    gnt = 1'b1;
    for (int i = 0; i < 3 * N + 2; i++) begin
      logic [3:0] r = exp_ready();
      tick();
      valid = valid & ~r;
    end
    valid = '0;
    tick();
  endtask

  task automatic set_beat(input int c, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    addr[c] = a; size[c] = s; data[c] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; gnt = 1'b0; valid = 4'b1111;
    for (int c = 0; c < N; c++) set_beat(c, $urandom, 2'($urandom_range(0, 3)), $urandom);
    #3;
    total++; if (ready !== 4'b0) $display("[TB] FAIL reset_ready: got %b want 0000", ready); else passed++;
    total++; if (l2_req !== 1'b0) $display("[TB] FAIL reset_req: got %b want 0", l2_req); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if ({l2_addr, l2_be, l2_wdata, l2_owner} !== '0)
      $display("[TB] FAIL reset_regs: got addr %h be %h wdata %h owner %0d want all 0", l2_addr, l2_be, l2_wdata, l2_owner);
    else passed++;
    do_reset();
  endtask

  task automatic test_byte_basic();
    set_beat(0, 32'h1C00_0003, 2'd0, 32'h0000_00A5);
    valid = 4'b0001; gnt = 1'b0;
    #1;
    total++; if (ready !== 4'b0001) $display("[TB] FAIL byte_ready: got %b want 0001", ready); else passed++;
    tick();
    valid = '0;
    total++; if (l2_req !== 1'b1) $display("[TB] FAIL byte_req: got %b want 1", l2_req); else passed++;
    total++; if (l2_addr !== 32'h1C00_0000) $display("[TB] FAIL byte_addr: got %h want 1c000000", l2_addr); else passed++;
    total++; if (l2_be !== 4'h8) $display("[TB] FAIL byte_be: got %h want 8", l2_be); else passed++;
    total++; if (l2_wdata !== 32'hA5A5_A5A5) $display("[TB] FAIL byte_wdata: got %h want a5a5a5a5", l2_wdata); else passed++;
    total++; if (l2_owner !== 2'd0) $display("[TB] FAIL byte_owner: got %0d want 0", l2_owner); else passed++;
    gnt = 1'b1;
    tick();
    total++; if (l2_req !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL byte_drop: got req %b busy %b want 0 0", l2_req, busy); else passed++;
    gnt = 1'b0;
  endtask

  task automatic test_round_robin();
    int seen [N] = '{default: 0};
    do_reset();
    for (int c = 0; c < N; c++) set_beat(c, $urandom, 2'($urandom_range(0, 3)), $urandom);
    valid = 4'b1111; gnt = 1'b1;
    for (int i = 0; i < 3 * N; i++) begin
      #1;
      total++; if (ready !== 4'(1 << (i % N))) $display("[TB] FAIL rr_order%0d: got %b want %b", i, ready, 4'(1 << (i % N))); else passed++;
      for (int c = 0; c < N; c++) seen[c] += int'(ready[c]);
      tick();
      total++; if ({l2_req, l2_addr, l2_be, l2_wdata, l2_owner} !== {1'b1, m_addr, m_be, m_wdata, 2'(i % N)})
        $display("[TB] FAIL rr_beat%0d: got %b %h %h %h %0d want 1 %h %h %h %0d", i, l2_req, l2_addr, l2_be, l2_wdata, l2_owner, m_addr, m_be, m_wdata, i % N);
      else passed++;
      set_beat(i % N, $urandom, 2'($urandom_range(0, 3)), $urandom);
    end
    for (int c = 0; c < N; c++) begin
      total++; if (seen[c] !== 3) $display("[TB] FAIL rr_share_ch%0d: got %0d accepts want 3", c, seen[c]); else passed++;
    end
    drain();
  endtask

  task automatic test_stall();
    set_beat(2, 32'h1C00_0010, 2'd2, 32'hCAFE_F00D);
    valid = 4'b0100; gnt = 1'b0;
    #1;
    total++; if (ready !== 4'b0100) $display("[TB] FAIL stall_accept: got %b want 0100", ready); else passed++;
    tick();
    set_beat(0, 32'h1C00_0020, 2'd1, 32'h0000_4321);
    set_beat(1, 32'h1C00_0031, 2'd0, 32'h0000_0077);
    valid = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (ready !== 4'b0000) $display("[TB] FAIL stall_ready%0d: got %b want 0000", i, ready); else passed++;
      tick();
      total++; if ({l2_req, l2_addr, l2_be, l2_wdata} !== {1'b1, 32'h1C00_0010, 4'hF, 32'hCAFE_F00D})
        $display("[TB] FAIL stall_hold%0d: got %b %h %h %h want 1 1c000010 f cafef00d", i, l2_req, l2_addr, l2_be, l2_wdata);
      else passed++;
    end
    drain();
  endtask

  task automatic test_alignment();
    logic [31:0] ta [8] = '{32'h1C00_0102, 32'h1C00_0201, 32'h1C00_0300, 32'h1C00_0301,
                            32'h1C00_0302, 32'h1C00_0403, 32'h1C00_0401, 32'h1C00_0503};
    logic [1:0]  ts [8] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3};
    logic [31:0] td [8] = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_005A, 32'h1234_56C3,
                            32'h0000_0011, 32'hABCD_5678, 32'h0000_BEEF, 32'h8765_4321};
    logic [3:0]  eb [8] = '{4'hC, 4'hF, 4'h1, 4'h2, 4'h4, 4'hC, 4'h3, 4'hF};
    logic [31:0] ew [8] = '{32'h1234_1234, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 32'hC3C3_C3C3,
                            32'h1111_1111, 32'h5678_5678, 32'hBEEF_BEEF, 32'h8765_4321};
    gnt = 1'b1; valid = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      set_beat(3, ta[i], ts[i], td[i]);
      tick();
      total++; if ({l2_addr, l2_be, l2_wdata} !== {ta[i] & ~32'h3, eb[i], ew[i]})
        $display("[TB] FAIL align%0d: got %h %h %h want %h %h %h", i, l2_addr, l2_be, l2_wdata, ta[i] & ~32'h3, eb[i], ew[i]);
      else passed++;
    end
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    gnt = 1'b1;
    set_beat(1, 32'h1C00_0100, 2'd2, 32'h1111_0000);
    valid = 4'b0010;
    tick();
    set_beat(1, 32'h1C00_0104, 2'd2, 32'h2222_0000);
    #1;
    total++; if (ready !== 4'b0010) $display("[TB] FAIL wrap_single: got %b want 0010", ready); else passed++;
    tick();
    total++; if (l2_owner !== 2'd1 || l2_wdata !== 32'h2222_0000) $display("[TB] FAIL wrap_owner: got %0d %h want 1 22220000", l2_owner, l2_wdata); else passed++;
    for (int c = 0; c < N; c++) set_beat(c, $urandom, 2'($urandom_range(0, 3)), $urandom);
    valid = 4'b1111;
    #1;
    total++; if (ready !== 4'b0100) $display("[TB] FAIL wrap_ptr: got %b want 0100", ready); else passed++;
    drain();
  endtask

  task automatic test_random();
    int waited [N] = '{default: 0};
    int max_wait = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [3:0] r;
      for (int c = 0; c < N; c++) begin
        if (!valid[c] && ($urandom % 2 == 0)) begin
          set_beat(c, $urandom, 2'($urandom_range(0, 3)), $urandom);
          valid[c] = 1'b1;
        end
      end
      gnt = ($urandom % 4) != 0;
      #1;
      r = exp_ready();
      total++; if (ready !== r) $display("[TB] FAIL rand_ready%0d: got %b want %b", cyc, ready, r); else passed++;
      if (r != 0) begin
        for (int c = 0; c < N; c++) begin
          if (r[c]) begin
            if (waited[c] > max_wait) max_wait = waited[c];
            waited[c] = 0;
          end else if (valid[c]) begin
            waited[c]++;
          end
        end
      end
      tick();
      total++; if ({l2_req, busy, l2_addr, l2_be, l2_wdata, l2_owner} !== {m_full, m_full, m_addr, m_be, m_wdata, m_owner})
        $display("[TB] FAIL rand_out%0d: got %b %b %h %h %h %0d want %b %b %h %h %h %0d", cyc,
                 l2_req, busy, l2_addr, l2_be, l2_wdata, l2_owner, m_full, m_full, m_addr, m_be, m_wdata, m_owner);
      else passed++;
      valid = valid & ~r;
    end
    total++; if (max_wait > N - 1) $display("[TB] FAIL rand_starve: got wait %0d want <= %0d", max_wait, N - 1); else passed++;
    drain();
  endtask

  task automatic test_reset_mid();
    gnt = 1'b0;
    set_beat(0, 32'h1C00_0040, 2'd2, 32'h0BAD_F00D);
    valid = 4'b0001;
    tick();
    set_beat(1, 32'h1C00_0050, 2'd2, $urandom);
    set_beat(2, 32'h1C00_0060, 2'd2, $urandom);
    valid = 4'b0110;
    #1;
    total++; if (l2_req !== 1'b1) $display("[TB] FAIL mid_pending: got %b want 1", l2_req); else passed++;
    #1;
    rst_n = 1'b0;
    #1;
    total++; if ({l2_req, busy, ready} !== 6'b0)
      $display("[TB] FAIL mid_async: got req %b busy %b ready %b want 0 0 0000", l2_req, busy, ready);
    else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    valid = '0;
    tick();
    total++; if (l2_req !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL mid_no_req: got %b %b want 0 0", l2_req, busy); else passed++;
    for (int c = 0; c < N; c++) set_beat(c, $urandom, 2'($urandom_range(0, 3)), $urandom);
    valid = 4'b1111; gnt = 1'b1;
    #1;
    total++; if (ready !== 4'b0001) $display("[TB] FAIL mid_ptr: got %b want 0001", ready); else passed++;
    drain();
  endtask

  initial begin
    rst_n = 1'b0; valid = '0; gnt = 1'b0; addr = '0; data = '0; size = '0;
    model_reset();
    test_reset();
    test_byte_basic();
    test_round_robin();
    test_stall();
    test_alignment();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
